// File: rtl/spike_threshold_unit.sv
// Threshold/refractory stage after LIF decay: compares a float potential against a
// programmable threshold, emits spikes and per-neuron refractory hold. Optional SPIKE_COUNT_EN.
module spike_threshold_unit #(
    parameter int unsigned NUM_NEURONS    = 16,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned REF_W          = 4,
    parameter int unsigned REFRACTORY     = 2,
    parameter logic [31:0] THRESHOLD_INIT = 32'h41F00000,
    parameter logic [31:0] V_RESET        = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              time_step,
    input  logic              cfg_we,
    input  logic [31:0]       cfg_threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_potential,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              out_spike,
    output logic              addr_err,
    output logic              busy
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]       spike_count
`endif
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OUT, S_SWEEP} state_t;

    state_t            state, state_n;
    logic              pending, pending_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       pot_q;
    logic [31:0]       threshold;
    logic [REF_W-1:0]  ref_cnt [NUM_NEURONS];
    logic [IDX_W-1:0]  sweep_idx;

    logic              out_valid_n, out_spike_n, addr_err_n, busy_n, in_ready_n;
    logic [ADDR_W-1:0] out_addr_n;
    logic [31:0]       out_potential_n;
    logic              arm_ref, dec_ref;

    // Map a float onto an unsigned key whose order matches numeric order; both zeros map alike.
    function automatic logic [31:0] order_key(input logic [31:0] f);
        if (f[31] && (f[30:0] != 31'd0))
            order_key = ~f;
        else
            order_key = {1'b1, f[30:0]};
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        in_range = 32'(a) < NUM_NEURONS;
    endfunction

    logic             q_in_range, q_nan, q_refr, q_ge, fire, reset_pot;
    logic [IDX_W-1:0] idx_q;

    assign idx_q      = addr_q[IDX_W-1:0];
    assign q_in_range = in_range(addr_q);
    assign q_nan      = (&pot_q[30:23]) && (|pot_q[22:0]);
    assign q_refr     = q_in_range && (ref_cnt[idx_q] != '0);
    assign q_ge       = order_key(pot_q) >= order_key(threshold);
    assign fire       = q_in_range && !q_nan && !q_refr && q_ge;
    assign reset_pot  = q_in_range && !q_nan && (q_refr || q_ge);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (pending)
                    state_n = S_SWEEP;
                else if (in_valid && in_ready)
                    state_n = S_EVAL;
            end
            S_EVAL:  state_n = S_OUT;
            S_OUT:   if (out_ready) state_n = pending ? S_SWEEP : S_IDLE;
            S_SWEEP: if (sweep_idx == LAST_IDX) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of every registered output plus datapath enables.
    always_comb begin
        pending_n       = pending;
        out_valid_n     = out_valid;
        out_addr_n      = out_addr;
        out_potential_n = out_potential;
        out_spike_n     = out_spike;
        addr_err_n      = 1'b0;
        arm_ref         = 1'b0;
        dec_ref         = 1'b0;

        // A pulse arriving on the sweep-entry cycle re-arms the next sweep.
        if (time_step)
            pending_n = 1'b1;
        else if ((state_n == S_SWEEP) && (state != S_SWEEP))
            pending_n = 1'b0;

        case (state)
            S_IDLE:  addr_err_n = (state_n == S_EVAL) && !in_range(in_addr);
            S_EVAL: begin
                out_valid_n     = 1'b1;
                out_addr_n      = addr_q;
                out_spike_n     = fire;
                out_potential_n = reset_pot ? V_RESET : pot_q;
                arm_ref         = fire;
            end
            S_OUT:   if (out_ready) out_valid_n = 1'b0;
            S_SWEEP: dec_ref = (ref_cnt[sweep_idx] != '0);
            default: ;
        endcase

        busy_n     = (state_n != S_IDLE);
        in_ready_n = (state_n == S_IDLE) && !pending_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            out_spike     <= 1'b0;
            addr_err      <= 1'b0;
            busy          <= 1'b0;
            addr_q        <= '0;
            pot_q         <= '0;
            sweep_idx     <= '0;
        end else begin
            pending       <= pending_n;
            in_ready      <= in_ready_n;
            out_valid     <= out_valid_n;
            out_addr      <= out_addr_n;
            out_potential <= out_potential_n;
            out_spike     <= out_spike_n;
            addr_err      <= addr_err_n;
            busy          <= busy_n;
            if ((state == S_IDLE) && (state_n == S_EVAL)) begin
                addr_q <= in_addr;
                pot_q  <= in_potential;
            end
            sweep_idx <= (state == S_SWEEP) ? sweep_idx + IDX_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            threshold <= THRESHOLD_INIT;
        else if (cfg_we)
            threshold <= cfg_threshold;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++)
                ref_cnt[i] <= '0;
        end else if (arm_ref) begin
            ref_cnt[idx_q] <= REF_W'(REFRACTORY);
        end else if (dec_ref) begin
            ref_cnt[sweep_idx] <= ref_cnt[sweep_idx] - REF_W'(1);
        end
    end

`ifdef SPIKE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            spike_count <= '0;
        else if (out_valid && out_ready && out_spike && (spike_count != 16'hFFFF))
            spike_count <= spike_count + 16'd1;
    end
`endif

endmodule

// File: doc/spike_threshold_unit.md
Name: spike_threshold_unit

Overview:
- Stage directly downstream of the LIF potential-decay block.
- Takes one decayed IEEE-754 single-precision membrane potential per transaction, tagged with a neuron address, and compares it against a configurable firing threshold.
- Tracks a per-neuron refractory counter. Emits a spike event and returns the potential to store back into neuron state: V_RESET if the neuron fired or is refractory, the input value otherwise.

Parameters:
- NUM_NEURONS, 16, number of neurons tracked (refractory array depth).
- ADDR_W, 12, neuron address width.
- REF_W, 4, refractory counter width.
- REFRACTORY, 2, timesteps a neuron is held after firing (0..2^REF_W-1).
- THRESHOLD_INIT, 32'h41F00000, threshold after reset (30.0).
- V_RESET, 32'h00000000, potential written back after a spike or during refractory (+0.0).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- time_step  in  1  single-cycle pulse marking the end of a timestep.
- cfg_we  in  1  threshold write strobe.
- cfg_threshold  in  32  new threshold, float.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept.
- in_addr  in  ADDR_W  neuron address.
- in_potential  in  32  decayed potential, float.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_addr  out  ADDR_W  echoed address.
- out_potential  out  32  write-back potential.
- out_spike  out  1  neuron fired (qualified by out_valid).
- addr_err  out  1  one-cycle pulse: address >= NUM_NEURONS.
- busy  out  1  sweep or transaction in progress.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - in_ready=0 in the reset cycle, 1 in the first cycle after.
  - out_valid=0, out_spike=0, addr_err=0, busy=0.
  - out_addr=0, out_potential=0.
  - Threshold register=THRESHOLD_INIT.
  - All refractory counters=0.
  - Pending-sweep flag=0.
- Reset asserted at any point aborts the in-flight transaction or sweep, with no output.
- FSM states: IDLE, EVAL, OUT, SWEEP.
- IDLE:
  - in_ready=1 only if no sweep is pending.
  - Accept on in_valid&&in_ready: latch addr and potential, go to EVAL.
  - If a sweep is pending, go to SWEEP instead; sweep has priority over a simultaneous in_valid.
- EVAL (1 cycle): compute result, register outputs, go to OUT.
  - out_valid rises the cycle after EVAL.
  - Accept-to-out_valid latency is 2 cycles.
- OUT: hold all outputs stable while out_valid&&!out_ready. On handshake go to IDLE, or SWEEP if pending. Back-to-back throughput is 1 transaction per 3 cycles.
- Evaluation rules, in priority order:
  - addr >= NUM_NEURONS: pass potential unchanged, out_spike=0, pulse addr_err in the EVAL cycle. No state change.
  - NaN input (exp=FF, mant!=0): pass unchanged, no spike.
  - Refractory counter != 0: out_potential=V_RESET, no spike.
  - potential >= threshold: out_spike=1, out_potential=V_RESET, counter<=REFRACTORY.
  - Otherwise: pass unchanged, no spike.
- Float compare:
  - Sign-magnitude ordering; +0 == -0.
  - +inf compares greater than any finite value.
  - Equality fires.
- time_step:
  - Sets the pending flag in any state, including during a sweep; it is re-armed for the next sweep.
  - Multiple pulses before a sweep starts merge into one.
- SWEEP:
  - Visits neurons 0..NUM_NEURONS-1, one per cycle, decrementing each nonzero counter. A counter at 0 stays 0.
  - Clears the pending flag on entry.
  - Lasts exactly NUM_NEURONS cycles, then returns to IDLE.
- busy=1 in EVAL, OUT and SWEEP.
- cfg_we: takes effect the next cycle in any state. A write in the EVAL cycle does not affect the current compare.

Optional Feature:
- SPIKE_COUNT_EN defined:
  - Adds output spike_count[15:0], reset to 0.
  - Increments on each out_valid&&out_ready with out_spike=1; saturates at 16'hFFFF.
- SPIKE_COUNT_EN undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then addr=3, potential=32'h41F80000 (31.0), out_ready=1 -> out_valid 2 cycles after accept, out_spike=1, out_potential=0, counter[3]=2.
- Same neuron, potential 40.0, before any time_step -> out_spike=0, out_potential=0 (refractory). After 2 time_step sweeps, 31.0 -> spikes again.
- addr=5, potential=32'h41F00000 (exactly 30.0) -> spike; 32'hC2000000 (-32.0) -> no spike, passed unchanged.
- addr=20 -> addr_err pulse, out_potential equals input, no spike; NaN 32'h7FC00000 -> no spike.
- out_ready held low 5 cycles with a time_step mid-hold -> outputs stable, in_ready=0; after handshake, SWEEP runs 16 cycles before next accept.
- cfg_we with 32'h41200000 (10.0), then potential 12.0 -> spike; rst_n low during SWEEP -> counters 0, out_valid 0, threshold back to 30.0.
